// File: rtl/fdiv_ctrl_pkg.sv
// Shared types and constants for the FP divide issue controller.
// The divider takes DIV_ITER_CYC cycles from issue until busy drops.
package fdiv_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      WB    = 2'd3
   } state_t;

   localparam int DIV_ITER_CYC  = 16;
   localparam int DRAIN_CYC_DEF = 3;
   localparam int MAX_WAIT_DEF  = DIV_ITER_CYC + 4;
   localparam int CNT_W         = 5;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/fdiv_hazard_cmp.sv
// Flags an ID-stage instruction that touches the in-flight divide destination,
// or is itself another divide, while a divide is pending.
module fdiv_hazard_cmp
   import fdiv_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] i_fd_q,
   input  logic             i_div_pending,
   input  logic             i_id_fdiv,
   input  logic [REG_W-1:0] i_id_fd,
   input  logic [REG_W-1:0] i_id_fs,
   input  logic [REG_W-1:0] i_id_ft,
   input  logic             i_id_use_fs,
   input  logic             i_id_use_ft,
   input  logic             i_id_fwe,
   output logic             o_hazard
);

   logic w_fs_hit;
   logic w_ft_hit;
   logic w_fd_hit;

   assign w_fs_hit = i_id_use_fs & (i_id_fs == i_fd_q);
   assign w_ft_hit = i_id_use_ft & (i_id_ft == i_fd_q);
   assign w_fd_hit = i_id_fwe    & (i_id_fd == i_fd_q);
   assign o_hazard = i_div_pending & (w_fs_hit | w_ft_hit | w_fd_hit | i_id_fdiv);

endmodule

// File: rtl/fdiv_issue_ctrl.sv
// Issues a divide to the Newton divider, freezes the pipe while it iterates,
// drains FPU stages e1..e3 and performs the one-cycle FP register write-back.
module fdiv_issue_ctrl
   import fdiv_ctrl_pkg::*;
#(
   parameter int REG_W     = 5,
   parameter int DRAIN_CYC = DRAIN_CYC_DEF,
   parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
   input  logic             i_clk,
   input  logic             i_clrn,
   input  logic             i_id_fdiv,
   input  logic [REG_W-1:0] i_id_fd,
   input  logic [REG_W-1:0] i_id_fs,
   input  logic [REG_W-1:0] i_id_ft,
   input  logic             i_id_use_fs,
   input  logic             i_id_use_ft,
   input  logic             i_id_fwe,
   input  logic             i_div_busy,
   input  logic [4:0]       i_div_count,
   output logic             o_fdiv,
   output logic             o_ena,
   output logic             o_pipe_stall,
   output logic             o_wb_fwe,
   output logic [REG_W-1:0] o_wb_fd,
   output logic             o_div_pending,
   output logic             o_err
);

   localparam logic [CNT_W-1:0] MAX_WAIT_C   = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] DRAIN_LAST_C = CNT_W'(DRAIN_CYC - 1);
   localparam state_t           DRAIN_ENTRY  = (DRAIN_CYC > 1) ? DRAIN : WB;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [REG_W-1:0] r_fd_q;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] r_drain_cnt;
   logic             r_err;

   logic             w_req;
   logic             w_pending;
   logic             w_hazard;
   logic             w_run_done;
   logic             w_issue;
   logic             w_wdog;
   logic             w_busy_err;
   logic [CNT_W-1:0] w_wait_inc;
   logic [CNT_W-1:0] w_drain_inc;

   // Request is masked during reset so every output idles while clrn is low.
   assign w_req       = i_id_fdiv & i_clrn;
   assign w_pending   = (r_state == RUN) | (r_state == DRAIN);
   assign w_run_done  = ~i_div_busy & (i_div_count != 5'd0);
   assign w_wait_inc  = sat_inc(r_wait_cnt);
   assign w_drain_inc = sat_inc(r_drain_cnt);
   assign o_err       = r_err;

   fdiv_hazard_cmp #(.REG_W(REG_W)) u_hazard (
      .i_fd_q        (r_fd_q),
      .i_div_pending (w_pending),
      .i_id_fdiv     (w_req),
      .i_id_fd       (i_id_fd),
      .i_id_fs       (i_id_fs),
      .i_id_ft       (i_id_ft),
      .i_id_use_fs   (i_id_use_fs),
      .i_id_use_ft   (i_id_use_ft),
      .i_id_fwe      (i_id_fwe),
      .o_hazard      (w_hazard)
   );

   // Next-state and handshake outputs; the busy-fall cycle already counts as the first drain cycle.
   always_comb begin
      w_state_nxt   = r_state;
      o_fdiv        = 1'b0;
      o_ena         = 1'b1;
      o_pipe_stall  = 1'b0;
      o_wb_fwe      = 1'b0;
      o_wb_fd       = {REG_W{1'b0}};
      o_div_pending = w_pending;
      w_issue       = 1'b0;
      w_wdog        = 1'b0;
      w_busy_err    = 1'b0;
      case (r_state)
         IDLE: begin
            w_issue      = w_req & ~w_hazard & ~i_div_busy;
            o_fdiv       = w_issue;
            o_pipe_stall = w_req;
            o_ena        = ~w_issue;
            if (w_issue) begin
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_run_done) begin
               o_ena        = 1'b1;
               o_pipe_stall = w_hazard;
               w_state_nxt  = DRAIN_ENTRY;
            end else if (w_wait_inc >= MAX_WAIT_C) begin
               o_ena        = 1'b0;
               o_pipe_stall = 1'b1;
               w_wdog       = 1'b1;
               w_state_nxt  = IDLE;
            end else begin
               o_ena        = 1'b0;
               o_pipe_stall = 1'b1;
               w_state_nxt  = RUN;
            end
         end
         DRAIN: begin
            o_ena        = 1'b1;
            o_pipe_stall = w_hazard;
            w_busy_err   = i_div_busy;
            if (r_drain_cnt >= DRAIN_LAST_C) begin
               w_state_nxt = WB;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         WB: begin
            o_wb_fwe     = 1'b1;
            o_wb_fd      = r_fd_q;
            o_pipe_stall = w_req;
            w_state_nxt  = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, latched destination, saturating counters and sticky error.
   always_ff @(posedge i_clk or negedge i_clrn) begin
      if (!i_clrn) begin
         r_state     <= IDLE;
         r_fd_q      <= {REG_W{1'b0}};
         r_wait_cnt  <= {CNT_W{1'b0}};
         r_drain_cnt <= {CNT_W{1'b0}};
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_wdog | w_busy_err) begin
            r_err <= 1'b1;
         end
         if (w_issue) begin
            r_fd_q     <= i_id_fd;
            r_wait_cnt <= {CNT_W{1'b0}};
         end else if (r_state == RUN) begin
            r_wait_cnt <= w_wait_inc;
         end
         if ((r_state == RUN) && w_run_done) begin
            r_drain_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
         end else if (r_state == DRAIN) begin
            r_drain_cnt <= w_drain_inc;
         end
      end
   end

endmodule

// File: doc/fdiv_issue_ctrl.md
Name: fdiv_issue_ctrl

Overview:
- Initiator side of the FPU divider handshake. Sits in the CPU ID/EXE control path.
- Launches a divide by pulsing fdiv to the Newton divider, and freezes the pipeline while the divider iterates.
- Drains the FPU pipeline stages e1..e3 with ena, then issues a one-cycle FP register write-back.
- Blocks dependent instructions in ID until the result is written back.

Parameters:
- REG_W, 5, FP register index width.
- DRAIN_CYC, 3, enabled cycles after busy falls before the result is valid at q.
- MAX_WAIT, 20, cycle limit in RUN before the watchdog error sets.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- id_fdiv  in  1  ID stage holds a valid fdiv instruction
- id_fd  in  REG_W  destination register of the ID instruction
- id_fs  in  REG_W  source register 1 of the ID instruction
- id_ft  in  REG_W  source register 2 of the ID instruction
- id_use_fs  in  1  ID instruction reads fs
- id_use_ft  in  1  ID instruction reads ft
- id_fwe  in  1  ID instruction writes an FP register
- div_busy  in  1  divider busy
- div_count  in  5  divider iteration counter
- fdiv  out  1  request to the divider
- ena  out  1  FPU pipeline enable
- pipe_stall  out  1  hold PC and IF/ID
- wb_fwe  out  1  FP register write enable for the divide result
- wb_fd  out  REG_W  write-back register index
- div_pending  out  1  a divide is in flight
- err  out  1  sticky watchdog error

Behaviour:
- Reset: clk and reset are one clock, clrn asynchronous active-low. All outputs are 0 in reset except ena=1. State=IDLE, fd_q=0, wait_cnt=0, drain_cnt=0. Reset mid-operation aborts silently; no wb_fwe is issued.
- States are IDLE, RUN, DRAIN, WB.
- IDLE:
  - fdiv = id_fdiv & ~hazard.
  - When fdiv=1: latch fd_q<=id_fd and go to RUN. pipe_stall=1 and ena=0 in that cycle, because the divider stall equation is fdiv & count==0.
  - A hazard here is a match against an in-flight fd_q. It is only possible in WB→IDLE overlap; see WB.
- RUN:
  - pipe_stall=1, ena=0, div_pending=1, wait_cnt increments each cycle.
  - Leave for DRAIN on the first cycle with div_busy=0 and div_count!=0. This is count 0x10, 16 cycles after the issue cycle T0.
  - If wait_cnt reaches MAX_WAIT: set err (sticky until reset), force the state to IDLE, no write-back.
- DRAIN:
  - ena=1, div_pending=1, drain_cnt counts 1..DRAIN_CYC, then go to WB.
  - pipe_stall = hazard, where hazard = div_pending & ((id_use_fs & id_fs==fd_q) | (id_use_ft & id_ft==fd_q) | (id_fwe & id_fd==fd_q) | id_fdiv).
  - Independent instructions advance.
- WB:
  - wb_fwe=1 and wb_fd=fd_q for exactly one cycle, ena=1, div_pending=0, then IDLE.
  - pipe_stall=id_fdiv: a new divide waits one cycle.
  - A dependent reader is released in this cycle; the register file write-through covers it.
- Nominal timeline: T0 issue, T1..T15 busy, T16..T18 drain, T19 wb_fwe, T20 next fdiv allowed.
- Simultaneous events:
  - div_busy already high at an IDLE fdiv request (a stray divider): treat it as a hazard and do not issue.
  - div_busy reasserting in DRAIN: set err, continue the drain.
- Width rule: wait_cnt and drain_cnt are 5 bits and saturate; no wrap.

Decomposition:
- Package fdiv_ctrl_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, WB=2'd3);
  - DIV_ITER_CYC=16;
  - DRAIN_CYC default;
  - MAX_WAIT default.
- One sub-module, fdiv_hazard_cmp, is combinational. Inputs: fd_q, div_pending, and the id_* fields. Output: hazard.

Test Plan:
- Single fdiv f3 with id_fd=3 at T0, divider model busy T1..T15:
  - fdiv high only at T0;
  - pipe_stall high T0..T15;
  - ena low T0..T15, high T16..;
  - wb_fwe=1 with wb_fd=3 only at T19.
- In DRAIN, an ID instruction reading fs=3 stalls until T19, while an ID instruction reading fs=4 gets pipe_stall=0 at T16.
- Back-to-back fdiv (f5, then f6): the second fdiv is held until T20 and issued at T20, with wb_fd=6 at T39.
- Divider model never drops busy: err=1 at T0+MAX_WAIT+1, state returns to IDLE, wb_fwe never asserts, err stays 1 until clrn.
- clrn pulsed low at T8:
  - all outputs reset immediately (asynchronous), ena=1;
  - no wb_fwe follows;
  - a fresh fdiv at T12 completes normally with write-back at T12+19.
- id_fdiv with div_busy=1 already in IDLE: fdiv stays 0 and pipe_stall=1 until div_busy drops, then issue.
